bcd_adder: RTL and testbench
============================

Name: bcd_adder

Overview:
- Registered, multi-digit packed-BCD adder: adds two BCD operands plus a carry-in; produces a BCD sum and a decimal carry-out.
- Sits in the datapath wherever decimal arithmetic is needed; single clock domain.
- One-cycle latency, with a simple valid-in/valid-out qualifier.

Parameters:
- NUM_DIGITS, default 2: number of BCD digits per operand; operand/sum width is 4*NUM_DIGITS bits (8 at default).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid this cycle; sample and add
- a  input  4*NUM_DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- b  input  4*NUM_DIGITS  operand B, packed BCD
- carry_in  input  1  decimal carry into digit 0
- sum  output  4*NUM_DIGITS  registered BCD sum
- carry  output  1  registered decimal carry out of the top digit
- out_valid  output  1  sum/carry updated by last edge
- in_error  output  1  (only with BCD_INPUT_CHECK_EN) some input digit > 9

Interface notes:
- One clock; reset is asynchronous and active-high. Clock is clk; reset is rst.
- All outputs are registered; no combinational input-to-output path.

Behaviour:
- Reset (rst=1, asynchronous, independent of clk): sum=0, carry=0, out_valid=0, in_error=0. Held while rst is high. Reset mid-operation discards any in-flight result.
- Per digit i, ripple from digit 0 upward, with c0=carry_in:
  - t_i = a_i + b_i + c_i, 5-bit unsigned.
  - If t_i > 9: s_i = (t_i + 6) mod 16 and c_{i+1} = 1.
  - Otherwise: s_i = t_i and c_{i+1} = 0.
- The final c_NUM_DIGITS is carry.
- Full ripple completes within one cycle; no pipelining between digits.
- On a rising clk with in_valid=1: sum and carry load the new result; out_valid=1 on the next cycle (latency 1).
- On a rising clk with in_valid=0: sum and carry hold their previous values; out_valid=0.
- Back-to-back in_valid is accepted every cycle (throughput 1/cycle). No backpressure.
- Boundaries:
  - Max input 99..9 + 99..9 + 1 gives sum 99..9 with carry=1.
  - All-zero inputs with carry_in=1 give sum 00..1.
  - Digit exactly 9 plus carry produces no spurious correction beyond the rule above.
- Non-BCD input digits (>9): the same rule is applied unchanged; the result is deterministic but not decimally meaningful. No internal state is corrupted.

Optional Feature:
- Macro: BCD_INPUT_CHECK_EN.
- Defined:
  - Port in_error exists.
  - On a clk edge with in_valid=1, in_error registers 1 if any digit of a or b exceeds 9, else 0.
  - in_error holds when in_valid=0 and resets to 0.
  - sum and carry are computed exactly as without the feature.
- Not defined: in_error port and its logic are absent; all other behaviour is identical.

Test Plan:
- 1. Reset: assert rst asynchronously mid-cycle after a nonzero result -> sum=00, carry=0, out_valid=0 immediately, without waiting for a clock edge.
- 2. No correction: a=45, b=27, carry_in=0, in_valid=1 -> one cycle later sum=72, carry=0, out_valid=1. Also a=00, b=00, carry_in=0 -> sum=00, carry=0.
- 3. Digit and top carry: a=59, b=73, cin=0 -> sum=32, carry=1. a=90, b=10, cin=0 -> sum=00, carry=1.
- 4. Maximum: a=99, b=99, cin=0 -> sum=98, carry=1. With cin=1 -> sum=99, carry=1.
- 5. Carry-in into a correcting digit: a=12, b=08, cin=1 -> sum=21, carry=0. Back-to-back issue of scenarios 2–5 on consecutive cycles gives each result exactly one cycle later. Deasserting in_valid holds the last sum and drops out_valid.
- 6. With BCD_INPUT_CHECK_EN: a=0A, b=00 -> in_error=1. Then a=45, b=27 -> in_error=0 and sum=72.

Source files
------------

// File: rtl/bcd_adder.sv
// bcd_adder: registered multi-digit packed-BCD adder with decimal carry, one-cycle latency.
// Define BCD_INPUT_CHECK_EN to add the registered in_error flag for non-BCD input digits.
module bcd_adder #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [4*NUM_DIGITS-1:0] a,
  input  logic [4*NUM_DIGITS-1:0] b,
  input  logic                    carry_in,
  output logic [4*NUM_DIGITS-1:0] sum,
  output logic                    carry,
`ifdef BCD_INPUT_CHECK_EN
  output logic                    in_error,
`endif
  output logic                    out_valid
);
  localparam int W = 4 * NUM_DIGITS;
  logic [W-1:0] sum_d, sum_q, res;
  logic carry_d, carry_q, res_c, out_valid_d, out_valid_q;
  always_comb begin
    logic [4:0] t;
    logic c;
    c = carry_in;
    t = '0;
    res = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      t = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0, c};
      c = t > 5'd9;
      res[4*i+:4] = c ? t[3:0] + 4'd6 : t[3:0];
    end
    res_c = c;
    sum_d = in_valid ? res : sum_q;
    carry_d = in_valid ? res_c : carry_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      carry_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      carry_q <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign sum = sum_q;
  assign carry = carry_q;
  assign out_valid = out_valid_q;
`ifdef BCD_INPUT_CHECK_EN
  logic in_error_d, in_error_q, bad;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      bad = bad | (a[4*i+:4] > 4'd9) | (b[4*i+:4] > 4'd9);
    in_error_d = in_valid ? bad : in_error_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_error_q <= 1'b0;
    else in_error_q <= in_error_d;
  end
  assign in_error = in_error_q;
`endif
endmodule

// File: tb/tb_bcd_adder.sv
// tb_bcd_adder: directed and randomized checks of bcd_adder against a decimal-arithmetic model.
module tb_bcd_adder;
  localparam int N = 2;
  localparam int W = 4 * N;
  logic clk = 0, rst = 1, in_valid = 0, carry_in = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic carry, out_valid;
  int checks = 0, errors = 0;
  logic [W-1:0] exp_sum = '0;
  logic exp_carry = 0;
`ifdef BCD_INPUT_CHECK_EN
  logic in_error;
`endif
  bcd_adder #(.NUM_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .carry_in(carry_in),
    .sum(sum), .carry(carry),
`ifdef BCD_INPUT_CHECK_EN
    .in_error(in_error),
`endif
    .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
    return r;
  endfunction
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic int lim();
    int p = 1;
    for (int i = 0; i < N; i++) p *= 10;
    return p;
  endfunction
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int t = to_int(x) + to_int(y) + int'(c);
    exp_sum = to_bcd(t % lim());
    exp_carry = t >= lim();
  endtask
  task automatic apply(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; carry_in = c; in_valid = 1;
    model(x, y, c);
    @(posedge clk); #1;
    check({tag, ".sum"}, 32'(sum), 32'(exp_sum));
    check({tag, ".carry"}, 32'(carry), 32'(exp_carry));
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
  endtask
  task automatic idle(input string tag);
    @(negedge clk);
    in_valid = 0;
    a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
    @(posedge clk); #1;
    check({tag, ".hold_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, ".hold_carry"}, 32'(carry), 32'(exp_carry));
    check({tag, ".valid_low"}, 32'(out_valid), 32'd0);
  endtask
  initial begin
    #12;
    check("rst.sum", 32'(sum), 0);
    check("rst.carry", 32'(carry), 0);
    check("rst.valid", 32'(out_valid), 0);
    @(negedge clk) rst = 0;
    apply("t2a", 8'h45, 8'h27, 0);
    apply("t2b", 8'h00, 8'h00, 0);
    apply("t3a", 8'h59, 8'h73, 0);
    apply("t3b", 8'h90, 8'h10, 0);
    apply("t4a", 8'h99, 8'h99, 0);
    apply("t4b", 8'h99, 8'h99, 1);
    apply("t5", 8'h12, 8'h08, 1);
    apply("zc", 8'h00, 8'h00, 1);
    apply("d9", 8'h09, 8'h00, 1);
    idle("t5i");
    idle("t5i2");
    apply("pre_rst", 8'h59, 8'h73, 0);
    #2 rst = 1;
    #1;
    check("arst.sum", 32'(sum), 0);
    check("arst.carry", 32'(carry), 0);
    check("arst.valid", 32'(out_valid), 0);
    exp_sum = '0; exp_carry = 0;
    @(negedge clk) rst = 0;
`ifdef BCD_INPUT_CHECK_EN
    apply("t6a", 8'h0A, 8'h00, 0);
    check("t6a.err", 32'(in_error), 1);
    apply("t6b", 8'h45, 8'h27, 0);
    check("t6b.err", 32'(in_error), 0);
    check("t6b.sum72", 32'(sum), 32'h72);
`endif
    for (int k = 0; k < 300; k++) begin
      logic [W-1:0] x, y;
      for (int i = 0; i < N; i++) begin
        x[4*i+:4] = 4'($urandom_range(9));
        y[4*i+:4] = 4'($urandom_range(9));
      end
      if ($urandom_range(4) == 0) idle("rnd_idle");
      else apply("rnd", x, y, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
